spi_slave_receiver: RTL and testbench
=====================================

Name: spi_slave_receiver

Overview:
SPI mode-0 responder, the slave-side counterpart to the parallel-load/serial-shift transmit register in the SPI interface. It oversamples SCLK, CS_N and MOSI on the system clock. It deserialises MSB-first MOSI frames into a parallel word with a valid/ack handshake, and shifts a preloaded response word out on MISO. It sits between the external SPI pins and the parallel data logic.

Parameters:
WIDTH, 4, bits per SPI frame (legal range 2..16)
SYNC_STAGES, 2, synchroniser flops on each SPI input (legal range 2..3)

Ports:
CLK  input  1  system clock; all state updates on its rising edge; must run at least 4x SCLK
CLR  input  1  asynchronous active-high reset
SCLK  input  1  SPI serial clock from master, asynchronous to CLK
CS_N  input  1  SPI chip select from master, active low
MOSI  input  1  serial data from master
MISO  output  1  serial data to master
TX_DATA  input  WIDTH  response word, sampled at frame start and at each word boundary
RX_DATA  output  WIDTH  last complete received word
RX_VALID  output  1  RX_DATA holds an unacknowledged word
RX_ACK  input  1  consumer acknowledge; clears RX_VALID
BUSY  output  1  frame in progress (state SHIFT)
OVERRUN  output  1  sticky; a word completed while RX_VALID was already 1

Behaviour:
- Reset (CLR=1, any time, asynchronous): state IDLE, bit counter 0, rx/tx shift regs 0, RX_DATA 0, RX_VALID 0, OVERRUN 0, BUSY 0, MISO 0. Synchroniser resets: SCLK 0, CS_N 1, MOSI 0. Reset mid-frame discards the partial word.
- Synchronisation: each input passes SYNC_STAGES flops, plus one history flop on SCLK and CS_N.
  - An edge is detected in the cycle where the synchronised value differs from the history value.
  - Edge-detect latency from pin is SYNC_STAGES+1 CLK cycles.
- States: IDLE, SHIFT.
- IDLE → SHIFT on CS_N fall:
  - tx_shift <= TX_DATA; MISO <= TX_DATA[WIDTH-1] in the same cycle; counter <= 0; BUSY <= 1.
  - An SCLK edge detected in the same cycle as a CS_N fall is ignored.
- SHIFT, SCLK rise:
  - rx_shift <= {rx_shift[WIDTH-2:0], MOSI_sync}; counter++.
  - When counter reaches WIDTH-1 before the increment (word complete): RX_DATA <= assembled word; RX_VALID <= 1 on the next CLK edge; counter <= 0.
- SHIFT, SCLK fall, counter != 0: tx_shift shifts left by 1; MISO <= new MSB.
- SHIFT, SCLK fall, counter == 0 after a completed word (back-to-back frames): tx_shift <= TX_DATA; MISO <= TX_DATA[WIDTH-1].
  - The first fall after CS_N assertion never reloads.
- SHIFT → IDLE on CS_N rise:
  - Partial word discarded; no RX_VALID; counter <= 0; BUSY <= 0; MISO <= 0.
  - A word completed in an earlier cycle is unaffected.
- Receive handshake:
  - RX_ACK=1 with RX_VALID=1 clears RX_VALID on the next edge.
  - RX_ACK while RX_VALID=0 has no effect.
  - Completion with RX_VALID=1 and no ACK: RX_DATA overwritten, RX_VALID stays 1, OVERRUN <= 1.
  - Completion and RX_ACK in the same cycle: new word loaded, RX_VALID stays 1, OVERRUN unchanged.
  - OVERRUN clears only on CLR.
- SCLK edges while CS_N is high are ignored. MISO is driven 0 whenever the state is IDLE.

Test Plan:
1. WIDTH=4, CLK=8x SCLK. Master sends 1011 MSB first; TX_DATA=4'b0110 → RX_DATA=4'hB, one RX_VALID assertion, and MISO bits seen by master at rises are 0,1,1,0.
2. Back-to-back frames 1100 then 0011 in one CS_N window; TX_DATA changed 6→9 between words; RX_ACK after each → RX_DATA=C then 3, and master receives 0110 then 1001.
3. Two words 1111 then 0001, no RX_ACK → RX_DATA=1, RX_VALID=1, OVERRUN=1; ACK then clears RX_VALID only.
4. CS_N deasserted after 2 bits (10), then new frame 0101 → no RX_VALID from the partial frame, then RX_DATA=5; BUSY falls within SYNC_STAGES+2 cycles of the CS_N rise.
5. CLR pulsed mid-frame after 3 bits → all outputs return to reset values immediately; next full frame 1001 yields RX_DATA=9.
6. SCLK toggled 4 times with CS_N=1 → no RX_VALID, BUSY=0, MISO=0.

Source files
------------

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave: oversampled SCLK/CS_N/MOSI, MSB-first receive into RX_DATA with
// valid/ack handshake, and a preloaded response word shifted out on MISO.
module spi_slave_receiver #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             SCLK,
    input  logic             CS_N,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] TX_DATA,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    input  logic             RX_ACK,
    output logic             BUSY,
    output logic             OVERRUN
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_p0, cs_p0, mosi_p0;
    logic                   sclk_p1, cs_p1;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       rx_shift, tx_shift;
    logic                   word_done;

    // Stage p0: synchroniser chains; stage p1: history flops for edge detection
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sclk_p0 <= '0;
            cs_p0   <= '1;
            mosi_p0 <= '0;
            sclk_p1 <= 1'b0;
            cs_p1   <= 1'b1;
        end else begin
            sclk_p0 <= {sclk_p0[SYNC_STAGES-2:0], SCLK};
            cs_p0   <= {cs_p0[SYNC_STAGES-2:0], CS_N};
            mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], MOSI};
            sclk_p1 <= sclk_p0[SYNC_STAGES-1];
            cs_p1   <= cs_p0[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_p0[SYNC_STAGES-1];
    assign cs_s      = cs_p0[SYNC_STAGES-1];
    assign mosi_s    = mosi_p0[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_p1;
    assign sclk_fall = ~sclk_s & sclk_p1;
    assign cs_fall   = ~cs_s & cs_p1;
    assign cs_rise   = cs_s & ~cs_p1;

    // Protocol state machine; CS_N edges take priority over SCLK edges
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            cnt       <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            word_done <= 1'b0;
            RX_DATA   <= '0;
            RX_VALID  <= 1'b0;
            OVERRUN   <= 1'b0;
            BUSY      <= 1'b0;
            MISO      <= 1'b0;
        end else begin
            if (RX_ACK && RX_VALID)
                RX_VALID <= 1'b0;

            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (cs_fall) begin
                        state     <= SHIFT;
                        tx_shift  <= TX_DATA;
                        MISO      <= TX_DATA[WIDTH-1];
                        cnt       <= '0;
                        BUSY      <= 1'b1;
                        word_done <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        BUSY      <= 1'b0;
                        MISO      <= 1'b0;
                        word_done <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                        if (cnt == CW'(WIDTH - 1)) begin
                            RX_DATA   <= {rx_shift[WIDTH-2:0], mosi_s};
                            RX_VALID  <= 1'b1;
                            if (RX_VALID && !RX_ACK)
                                OVERRUN <= 1'b1;
                            cnt       <= '0;
                            word_done <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        if (cnt != '0) begin
                            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                            MISO     <= tx_shift[WIDTH-2];
                        end else if (word_done) begin
                            // Back-to-back word: fetch the next response
                            tx_shift  <= TX_DATA;
                            MISO      <= TX_DATA[WIDTH-1];
                            word_done <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Directed bench for spi_slave_receiver: bench-side SPI master with a scoreboard of
// expected received words and expected MISO bits.
module tb_spi_slave_receiver;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;

    logic             CLK = 1'b0;
    logic             CLR = 1'b1;
    logic             SCLK = 1'b0;
    logic             CS_N = 1'b1;
    logic             MOSI = 1'b0;
    logic             MISO;
    logic [WIDTH-1:0] TX_DATA = '0;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic             RX_ACK = 1'b0;
    logic             BUSY;
    logic             OVERRUN;

    int tests = 0;
    int fails = 0;
    int vrises = 0;
    logic vprev = 1'b0;

    logic [WIDTH-1:0] rx_q[$];
    logic             miso_q[$];

    spi_slave_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .CLR(CLR), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
        .TX_DATA(TX_DATA), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ACK(RX_ACK),
        .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        vprev <= RX_VALID;
        if (RX_VALID && !vprev) vrises <= vrises + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SCLK half period = 4 system clocks (CLK runs 8x SCLK)
    task automatic half();
        repeat (4) @(negedge CLK);
    endtask

    task automatic cs_start(input logic [WIDTH-1:0] tx);
        TX_DATA = tx;
        CS_N = 1'b0;
        half();
    endtask

    task automatic cs_end();
        half();
        CS_N = 1'b1;
        half();
        half();
    endtask

    task automatic send_bits(input logic [15:0] d, input int n, input logic [WIDTH-1:0] tx_now,
                             input logic [WIDTH-1:0] tx_next, input bit push_rx);
        logic exp_bit;
        if (push_rx) rx_q.push_back(d[WIDTH-1:0]);
        for (int i = 0; i < n; i++) miso_q.push_back(tx_now[WIDTH-1-i]);
        for (int i = 0; i < n; i++) begin
            MOSI = d[n-1-i];
            half();
            SCLK = 1'b1;
            exp_bit = miso_q.pop_front();
            check("miso_bit", {15'd0, MISO}, {15'd0, exp_bit});
            if (i == n - 1) TX_DATA = tx_next;
            half();
            SCLK = 1'b0;
        end
    endtask

    task automatic wait_valid(input string tag);
        logic [WIDTH-1:0] exp_w;
        for (int k = 0; k < 40 && !RX_VALID; k++) @(negedge CLK);
        check({tag, "_valid"}, {15'd0, RX_VALID}, 16'd1);
        if (rx_q.size() > 0) begin
            exp_w = rx_q.pop_front();
            check({tag, "_data"}, {12'd0, RX_DATA}, {12'd0, exp_w});
        end else begin
            check({tag, "_queue_nonempty"}, 16'd0, 16'd1);
        end
    endtask

    task automatic ack(input string tag);
        RX_ACK = 1'b1;
        @(negedge CLK);
        RX_ACK = 1'b0;
        check({tag, "_ack_clears"}, {15'd0, RX_VALID}, 16'd0);
    endtask

    initial begin
        int v0;
        int k;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_rx_data", {12'd0, RX_DATA}, 16'd0);
        check("rst_rx_valid", {15'd0, RX_VALID}, 16'd0);
        check("rst_busy", {15'd0, BUSY}, 16'd0);
        check("rst_miso", {15'd0, MISO}, 16'd0);
        check("rst_overrun", {15'd0, OVERRUN}, 16'd0);
        CLR = 1'b0;
        half();

        // 1: single frame 1011, response 0110
        v0 = vrises;
        cs_start(4'b0110);
        check("t1_busy", {15'd0, BUSY}, 16'd1);
        send_bits(16'b1011, 4, 4'b0110, 4'b0110, 1'b1);
        wait_valid("t1");
        cs_end();
        check("t1_one_valid", vrises - v0, 16'd1);
        check("t1_busy_idle", {15'd0, BUSY}, 16'd0);
        ack("t1");

        // 2: back-to-back words, response 6 then 9
        cs_start(4'h6);
        send_bits(16'b1100, 4, 4'h6, 4'h9, 1'b1);
        wait_valid("t2a");
        ack("t2a");
        send_bits(16'b0011, 4, 4'h9, 4'h9, 1'b1);
        wait_valid("t2b");
        ack("t2b");
        cs_end();
        check("t2_overrun", {15'd0, OVERRUN}, 16'd0);

        // 3: two words without ack -> overrun
        cs_start(4'h0);
        send_bits(16'b1111, 4, 4'h0, 4'h0, 1'b0);
        send_bits(16'b0001, 4, 4'h0, 4'h0, 1'b1);
        cs_end();
        wait_valid("t3");
        check("t3_overrun", {15'd0, OVERRUN}, 16'd1);
        ack("t3");
        check("t3_overrun_sticky", {15'd0, OVERRUN}, 16'd1);

        // 4: partial frame aborted, then full frame 0101
        cs_start(4'h0);
        send_bits(16'b10, 2, 4'h0, 4'h0, 1'b0);
        half();
        CS_N = 1'b1;
        k = 0;
        while (BUSY && k < SYNC + 2) begin
            @(negedge CLK);
            k++;
        end
        check("t4_busy_fall", {15'd0, BUSY}, 16'd0);
        check("t4_miso_idle", {15'd0, MISO}, 16'd0);
        half();
        check("t4_no_valid", {15'd0, RX_VALID}, 16'd0);
        cs_start(4'hA);
        send_bits(16'b0101, 4, 4'hA, 4'hA, 1'b1);
        wait_valid("t4");
        cs_end();
        ack("t4");

        // 5: asynchronous clear mid-frame
        cs_start(4'hF);
        send_bits(16'b101, 3, 4'hF, 4'hF, 1'b0);
        #2 CLR = 1'b1;
        #1;
        check("t5_rx_data", {12'd0, RX_DATA}, 16'd0);
        check("t5_busy", {15'd0, BUSY}, 16'd0);
        check("t5_miso", {15'd0, MISO}, 16'd0);
        check("t5_overrun", {15'd0, OVERRUN}, 16'd0);
        check("t5_valid", {15'd0, RX_VALID}, 16'd0);
        CS_N = 1'b1;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        half();
        check("t5_idle_after", {15'd0, BUSY}, 16'd0);
        cs_start(4'h3);
        send_bits(16'b1001, 4, 4'h3, 4'h3, 1'b1);
        wait_valid("t5");
        cs_end();
        ack("t5");

        // 6: SCLK toggles with CS_N high are ignored
        for (int i = 0; i < 8; i++) begin
            MOSI = i[0];
            SCLK = ~SCLK;
            half();
            check("t6_valid", {15'd0, RX_VALID}, 16'd0);
            check("t6_busy", {15'd0, BUSY}, 16'd0);
            check("t6_miso", {15'd0, MISO}, 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
